// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable baud divisor.
// Optional TX-done interrupt enabled by defining TX_IRQ_EN.
module mmio_uart_tx #(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wren,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   baud_div_q, baud_div_d, div_act_q, div_act_d, baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d, overflow_q, overflow_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic          hit_q, hit_d;
  logic [31:0]   data_out_q, data_out_d;

  logic          in_win, wr_hit, push_req, push_ok, pop, start_frame, baud_end;
  logic          empty, full, busy;
  logic [PW-1:0] count, count_d;
  logic [1:0]    cnt_sat;
  logic [31:0]   reg_word, lane, ld_word;
  logic          unused_data;

  assign unused_data = ^data_in[31:16];

  // Address decode, status and registered load path
  always_comb begin
    in_win  = (address[31:4] == BASE_ADDR[31:4]);
    wr_hit  = wren & in_win;
    count   = wr_ptr_q - rd_ptr_q;
    empty   = (count == '0);
    full    = (count == PW'(FIFO_DEPTH));
    busy    = (state_q != S_IDLE);
    cnt_sat = (count > PW'(3)) ? 2'd3 : count[1:0];
    case (address[3:2])
      2'd1:    reg_word = {25'b0, irq_en_q, overflow_q, busy, full, empty, cnt_sat};
      2'd2:    reg_word = {16'b0, baud_div_q};
      default: reg_word = '0;
    endcase
    lane = reg_word >> {address[1:0], 3'b000};
    case (funct3)
      3'b000:  ld_word = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_word = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_word = {24'b0, lane[7:0]};
      3'b101:  ld_word = {16'b0, lane[15:0]};
      default: ld_word = reg_word;
    endcase
    data_out_d = in_win ? ld_word : '0;
    hit_d      = in_win;
  end

  // Serialiser FSM, FIFO pointers and register writes
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    shift_d     = shift_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    div_act_d   = div_act_q;
    baud_div_d  = baud_div_q;
    overflow_d  = overflow_q;
    irq_en_d    = irq_en_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    baud_end    = (baud_cnt_q == div_act_q - 16'd1);

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) start_frame = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = S_DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d   = S_STOP;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
    endcase

    // Frame start: pop head byte and freeze the divisor for the whole frame
    if (start_frame) begin
      pop        = 1'b1;
      shift_d    = mem_q[rd_ptr_q[AW-1:0]];
      div_act_d  = baud_div_q;
      state_d    = S_START;
      tx_d       = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end

    push_req = wr_hit && (address[3:2] == 2'd0);
    push_ok  = push_req && (!full || pop);

    if (wr_hit && (address[3:2] == 2'd1)) begin
      if (data_in[5]) overflow_d = 1'b0;
`ifdef TX_IRQ_EN
      irq_en_d = data_in[6];
`endif
    end
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (wr_hit && (address[3:2] == 2'd2))
      baud_div_d = (data_in[15:0] < 16'd2) ? 16'd2 : data_in[15:0];

    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = wr_ptr_d - rd_ptr_d;
`ifdef TX_IRQ_EN
    irq_d = irq_en_d && (count_d == '0) && (state_d == S_IDLE);
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      baud_div_q <= DIV_RST;
      div_act_q  <= DIV_RST;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      hit_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      baud_div_q <= baud_div_d;
      div_act_q  <= div_act_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      hit_q      <= hit_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign hit      = hit_q;
  assign tx       = tx_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx: a frame-level model predicts every tx waveform
// and register readback. Define TX_IRQ_EN to also exercise the interrupt.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wren = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        hit, tx, irq;

  mmio_uart_tx #(.CLK_FREQ(12000000), .BAUD(115200), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wren(wren), .funct3(funct3), .address(address),
    .data_in(data_in), .data_out(data_out), .hit(hit), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] exp_q[$];
  int         starts[$];
  int         model_div = 104;
  logic       model_ovf = 1'b0;
  logic       model_irq_en = 1'b0;
  logic       mon_busy = 1'b0;
  logic       mon_stop = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic frame_level(int t, int d, logic [7:0] b);
    int k;
    k = t / d;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [31:0] status_exp(logic busy);
    int c;
    c = exp_q.size();
    return {25'b0, model_irq_en, model_ovf, busy, (c == DEPTH), (c == 0), (c > 3) ? 2'd3 : 2'(c)};
  endfunction

  // Frame monitor: every falling start edge must match the next predicted byte at the live divisor
  initial begin
    int d, errs;
    logic [7:0] exb, got;
    forever begin
      @(negedge clk);
      if (mon_stop || tx !== 1'b0) continue;
      mon_busy = 1'b1;
      d = model_div;
      starts.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
        exb = 8'h00;
      end else begin
        exb = exp_q.pop_front();
      end
      errs = 0;
      got  = 8'h00;
      for (int t = 0; t < 10 * d; t++) begin
        if (t > 0) @(negedge clk);
        if (mon_stop) break;
        if (tx !== frame_level(t, d, exb)) errs++;
        if ((t % d) == d / 2 && t / d >= 1 && t / d <= 8) got[t/d-1] = tx;
      end
      if (!mon_stop) begin
        check("frame_bits", 32'(errs), 32'd0);
        check("frame_byte", {24'b0, got}, {24'b0, exb});
      end
      mon_busy = 1'b0;
    end
  end

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] data, input logic [2:0] f3);
    address = BASE + {28'b0, off};
    data_in = data;
    funct3  = f3;
    wren    = 1'b1;
    @(posedge clk);
    #1 wren = 1'b0;
    if (off[3:2] == 2'd1) begin
      if (data[5]) model_ovf = 1'b0;
`ifdef TX_IRQ_EN
      model_irq_en = data[6];
`endif
    end
    if (off[3:2] == 2'd2) model_div = (data[15:0] < 16'd2) ? 2 : int'(data[15:0]);
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic [2:0] f3,
                        output logic [31:0] val, output logic h);
    address = addr;
    funct3  = f3;
    wren    = 1'b0;
    @(posedge clk);
    #1 val = data_out;
    h = hit;
  endtask

  task automatic push(input logic [7:0] b);
    logic [2:0] f3;
    case ($urandom_range(0, 2))
      0:       f3 = 3'b000;
      1:       f3 = 3'b001;
      default: f3 = 3'b010;
    endcase
    if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
    else exp_q.push_back(b);
    bus_wr(4'h0, {24'($urandom), b}, f3);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mon_busy) break;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(input int budget);
    for (int i = 0; i < budget && !mon_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("frame_start_timeout", 32'(mon_busy), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic        h;
    int          n;

    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and register map
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    bus_rd(BASE + 32'h4, 3'b010, v, h);
    check("reset_status", v, 32'h04);
    check("hit_in", 32'(h), 32'd1);
    bus_rd(BASE + 32'h8, 3'b010, v, h);
    check("reset_baud", v, 32'd104);
    bus_rd(BASE + 32'hC, 3'b010, v, h);
    check("reserved_rd", v, 32'd0);
    bus_rd(BASE + 32'h0, 3'b010, v, h);
    check("txdata_rd", v, 32'd0);
    bus_rd(BASE + 32'h14, 3'b010, v, h);
    check("oow_data", v, 32'd0);
    check("hit_out", 32'(h), 32'd0);

    // Single 0x55 frame at the reset divisor
    push(8'h55);
    wait_done(2000);

    // Back-to-back frames at div 4
    bus_wr(4'h8, 32'd4, 3'b010);
    starts.delete();
    push(8'hA5);
    push(8'h3C);
    wait_done(300);
    check("b2b_frames", 32'(starts.size()), 32'd2);
    if (starts.size() == 2) check("b2b_gap", 32'(starts[1] - starts[0]), 32'd40);

    // Random bursts at random divisors
    for (int it = 0; it < 4; it++) begin
      bus_wr(4'h8, 32'($urandom_range(2, 6)), 3'b010);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) push(8'($urandom));
      wait_done(600);
    end

    // Overflow: stall in a long frame then push nine more bytes
    bus_wr(4'h8, 32'd20, 3'b010);
    push(8'($urandom));
    repeat (5) @(posedge clk);
    #1;
    for (int j = 0; j < 9; j++) push(8'($urandom));
    bus_rd(BASE + 32'h4, 3'b010, v, h);
    check("status_full_ovf", v, status_exp(1'b1));
    check("ovf_bit", 32'(v[5]), 32'd1);
    bus_wr(4'h4, 32'h20, 3'b010);
    bus_rd(BASE + 32'h4, 3'b010, v, h);
    check("status_w1c", v, status_exp(1'b1));
    wait_done(3000);

    // Divisor change mid-frame applies to the next frame only
    bus_wr(4'h8, 32'd4, 3'b010);
    push(8'($urandom));
    wait_frame(20);
    repeat (6) @(posedge clk);
    #1;
    bus_wr(4'h8, 32'd2, 3'b010);
    push(8'($urandom));
    wait_done(300);

    // Divisor clamp, upper-bit masking and narrow loads
    bus_wr(4'h8, 32'd1, 3'b010);
    bus_rd(BASE + 32'h8, 3'b010, v, h);
    check("baud_clamp1", v, 32'd2);
    bus_wr(4'h8, 32'd0, 3'b010);
    bus_rd(BASE + 32'h8, 3'b010, v, h);
    check("baud_clamp0", v, 32'd2);
    bus_wr(4'h8, 32'hABCD_1234, 3'b010);
    bus_rd(BASE + 32'h8, 3'b010, v, h);
    check("baud_upper", v, 32'h0000_1234);
    bus_wr(4'h8, 32'h80, 3'b010);
    bus_rd(BASE + 32'h9, 3'b000, v, h);
    check("lb_off9", v, 32'h0);
    bus_rd(BASE + 32'h8, 3'b000, v, h);
    check("lb_off8", v, 32'hFFFF_FF80);
    bus_rd(BASE + 32'h8, 3'b100, v, h);
    check("lbu_off8", v, 32'h80);
    bus_rd(BASE + 32'h8, 3'b001, v, h);
    check("lh_off8", v, 32'h80);

    // Reset mid-DATA aborts the frame
    bus_wr(4'h8, 32'd4, 3'b010);
    push(8'($urandom));
    wait_frame(20);
    repeat (15) @(posedge clk);
    mon_stop = 1'b1;
    #2 reset = 1'b0;
    #1 check("rst_tx_high", 32'(tx), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    model_div = 104;
    model_ovf = 1'b0;
    model_irq_en = 1'b0;
    mon_stop = 1'b0;
    bus_rd(BASE + 32'h4, 3'b010, v, h);
    check("rst_status", v, 32'h04);
    bus_rd(BASE + 32'h8, 3'b010, v, h);
    check("rst_baud", v, 32'd104);
    repeat (20) @(posedge clk);
    #1 check("rst_no_frame", 32'(mon_busy), 32'd0);

    // Interrupt behaviour
    bus_wr(4'h8, 32'd4, 3'b010);
    bus_wr(4'h4, 32'h40, 3'b010);
    bus_rd(BASE + 32'h4, 3'b010, v, h);
    check("irq_en_status", v, status_exp(1'b0));
`ifdef TX_IRQ_EN
    check("irq_idle", 32'(irq), 32'd1);
    push(8'($urandom));
    check("irq_push_clr", 32'(irq), 32'd0);
    wait_done(300);
    check("irq_done", 32'(irq), 32'd1);
    push(8'($urandom));
    check("irq_push_clr2", 32'(irq), 32'd0);
    wait_done(300);
    bus_wr(4'h4, 32'h00, 3'b010);
    @(posedge clk);
    #1 check("irq_disable", 32'(irq), 32'd0);
`else
    push(8'($urandom));
    wait_done(300);
    check("irq_tied", 32'(irq), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
